// File: rtl/mult32_seq_pkg.sv
// ---------------------------------------------------------------------------
// mult32_seq_pkg
// Shared definitions for the sequential shift-add multiplier.
//   state_t   : FSM encoding (code 3 is unused and decodes as IDLE)
//   DATA_W    : operand width of the fixed 32-bit adder datapath
//   PROD_W    : product width
//   MUL_ITER  : number of shift-add steps per multiply
// ---------------------------------------------------------------------------
package mult32_seq_pkg;

  localparam int DATA_W   = 32;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult32_seq_if.sv
// ---------------------------------------------------------------------------
// mult32_seq_if
// Issue/result bundle between the ALU (master) and the multiplier (slave).
//   start   : master -> slave, request, sampled only when the slave is not busy
//   a, b    : master -> slave, operands, captured on an accepted start
//   busy    : slave -> master, high while the multiply is running
//   done    : slave -> master, one-cycle pulse, product valid
//   product : slave -> master, held result {hi,lo}
//   hi_nz   : slave -> master, product[63:32] != 0
// Handshake: start is accepted on a rising edge when busy is low; start seen
// while busy is high is dropped. There is no back-pressure on the result:
// product/hi_nz are valid from the done cycle until the next accepted start.
// ---------------------------------------------------------------------------
interface mult32_seq_if;
  import mult32_seq_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;
  logic              hi_nz;

  modport master (
    output start, a, b,
    input  busy, done, product, hi_nz
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, hi_nz
  );

endinterface

// File: rtl/adder32bit.sv
// ---------------------------------------------------------------------------
// adder32bit
// 32-bit ripple-carry adder used for the multiplier step add.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, low 32 bits
//   cout : carry out of bit 31
// ---------------------------------------------------------------------------
module adder32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[32];
  end

endmodule

// File: rtl/mult32_seq.sv
// ---------------------------------------------------------------------------
// mult32_seq
// Sequential unsigned 32x32 -> 64 shift-add multiplier, one bit per cycle.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of mult32_seq_if (start/a/b in, busy/done/
//               product/hi_nz out)
//   dbg_state : current FSM state
// The multiplier operand lives in lo and is consumed LSB first; each RUN
// edge adds mcand (or 0) to hi and shifts the 65-bit {cout,sum,lo} right.
// After 32 steps {hi,lo} is the exact product. All outputs are flops.
// ---------------------------------------------------------------------------
module mult32_seq
  import mult32_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  mult32_seq_if.slave  bus,
  output state_t       dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               hi_nz_q, hi_nz_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               accept;

  assign add_b = lo_q[0] ? mcand_q : '0;

  adder32bit u_adder (
    .a    (hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Start is honoured in IDLE, DONE and the unused code; never during RUN.
  assign accept = bus.start && (state_q != ST_RUN);

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_RUN: begin
        hi_d  = {add_cout, add_sum[WIDTH-1:1]};
        lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        // DONE lasts one cycle; the unused code falls back to IDLE.
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      state_d = ST_RUN;
      mcand_d = bus.a;
      lo_d    = bus.b;
      hi_d    = '0;
      cnt_d   = '0;
    end

    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    hi_nz_d = |hi_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_nz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_nz_q <= hi_nz_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi_nz   = hi_nz_q;
  assign bus.product = {hi_q, lo_q};
  assign dbg_state   = state_q;

endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
- Sequential unsigned 32x32 -> 64-bit shift-add multiplier for the execute stage.
- It is the stage directly downstream of the 32-bit ripple adder. Each cycle it registers the adder's sum and carry-out into a partial-product accumulator, shifts, and feeds the upper half back as adder operand A.
- The ALU issues it with a start pulse and reads a held 64-bit product.
- One bit per cycle; no lookahead or early termination.

Parameters:
- WIDTH, 32: operand width. Only 32 is legal because the adder datapath is fixed at 32 bits.
- CNT_W, 6: iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  32  multiplicand; captured on accepted start
- b  in  32  multiplier; captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; product valid
- product  out  64  {hi,lo} result; held until next accepted start
- hi_nz  out  1  product[63:32] != 0; valid with product

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, product=0, hi_nz=0; counter=0, mcand=0.
  - Reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: start=1 -> RUN. Capture mcand<=a, lo<=b, hi<=0, cnt<=0.
  - RUN: perform one step per edge. On the edge where cnt==31 completes, go to DONE.
  - DONE: done=1 for this cycle only. start=1 -> RUN with the same capture as IDLE (back-to-back issue allowed). Otherwise -> IDLE.
- Step (RUN edge):
  - Adder inputs: A=hi, B = lo[0] ? mcand : 0, Cin=0, producing sum and cout.
  - Update: {hi,lo} <= {cout, sum, lo[31:1]} (65-bit value shifted right one).
  - cnt <= cnt+1.
- Latency: start accepted at edge k; done high in the cycle after edge k+32; next issue earliest at edge k+33.
- start while busy (RUN) is ignored and has no effect on the operation in progress.
- a/b may change freely after the accepting edge.
- product = {hi,lo}. It is stable during DONE and IDLE. During RUN it shows the intermediate partial product and must not be consumed.
- Arithmetic: exact unsigned product; no overflow possible at 64 bits. hi_nz flags that the result does not fit in 32 bits.
- Boundary cases:
  - a=0 or b=0 gives product 0.
  - a=b=32'hFFFFFFFF must propagate cout into bit 63 correctly.
  - cnt wrap at 32 never occurs, because the state leaves RUN first.
- Outputs are registered; no combinational path from start/a/b to any output.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; code 3 is treated as IDLE.
  - MUL_ITER=32.
- One sub-module: instantiate the existing adder32bit for the step add, with Cin tied to 0.
- The FSM, counter and accumulator stay in mult32_seq.

Test Plan:
- Reset-mid-run: rst_n low at cycle 5 after start with a=7, b=9 -> all outputs 0, state IDLE. A later start with a=3, b=5 -> product=15.
- Basic: start with a=6, b=7 -> done pulses exactly 33 cycles after the start edge; product=64'd42, hi_nz=0; busy high for 32 cycles.
- Max operands: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001, hi_nz=1.
- Zero operand: a=32'h12345678, b=0 -> product=0, hi_nz=0, still 33-cycle latency.
- Ignored start: start re-pulsed with a=1, b=1 at cycle 10 of a run with a=100, b=200 -> product=20000, single done pulse.
- Back-to-back: start asserted during DONE with a=2^16, b=2^16 -> returns to RUN without an IDLE cycle; second product=64'h100000000, hi_nz=1; previous product held through the DONE cycle.
